multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with memory-wait timeout.
// Strobes are combinational from state and inputs; MemReady low stalls FETCH/MEM up to WAIT_LIMIT cycles.
module multicycle_controller #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_SYSCALL = 1'b1,
  parameter int WAIT_LIMIT      = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Z,
  input  logic             MemReady,
  output logic             IrWrite,
  output logic             PcWrite,
  output logic             Rmem,
  output logic             Wmem,
  output logic             Wreg,
  output logic [1:0]       Regrt,
  output logic             Se,
  output logic             Aluqb,
  output logic [1:0]       Aluc,
  output logic [1:0]       Pcsrc,
  output logic [1:0]       Reg2reg,
  output logic [2:0]       State,
  output logic             Halted,
  output logic             Error,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_SYS  = 6'h0c;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       wait_cnt;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ir_wr, pc_wr, rd_mem, wr_mem, wr_reg;
  logic [1:0]       pcsrc;

  logic is_r, is_addu, is_subu, is_jr, is_sys, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, is_alu, is_illegal, waiting, timeout;

  assign is_r       = (Op == OP_R);
  assign is_addu    = is_r && (Func == F_ADDU);
  assign is_subu    = is_r && (Func == F_SUBU);
  assign is_jr      = is_r && (Func == F_JR);
  assign is_sys     = is_r && (Func == F_SYS);
  assign is_ori     = (Op == OP_ORI);
  assign is_lui     = (Op == OP_LUI);
  assign is_lw      = (Op == OP_LW);
  assign is_sw      = (Op == OP_SW);
  assign is_beq     = (Op == OP_BEQ);
  assign is_j       = (Op == OP_J);
  assign is_jal     = (Op == OP_JAL);
  assign is_alu     = is_addu || is_subu || is_ori || is_lui;
  assign is_illegal = !(is_alu || is_jr || is_sys || is_lw || is_sw || is_beq || is_j || is_jal);

  // The timeout cycle is the WAIT_LIMIT-th consecutive cycle without MemReady.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout = waiting && !MemReady && (wait_cnt == WAIT_LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (MemReady)     state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: begin
        if (is_sys && HALT_ON_SYSCALL) state_d = S_HALT;
        else if (is_sys || is_illegal) state_d = S_FETCH;
        else                           state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw) state_d = S_MEM;
        else if (is_alu)    state_d = S_WB;
        else                state_d = S_FETCH;
      end
      S_MEM: begin
        if (MemReady)     state_d = is_lw ? S_WB : S_FETCH;
        else if (timeout) state_d = S_HALT;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_wr  = 1'b0;
    pc_wr  = 1'b0;
    rd_mem = 1'b0;
    wr_mem = 1'b0;
    wr_reg = 1'b0;
    pcsrc  = 2'b00;
    case (state_q)
      S_FETCH: begin
        rd_mem = !timeout;
        ir_wr  = MemReady;
      end
      S_DECODE: pc_wr = (is_sys && !HALT_ON_SYSCALL) || is_illegal;
      S_EXEC: begin
        if (is_beq) begin
          pc_wr = 1'b1;
          pcsrc = Z ? 2'b10 : 2'b00;
        end else if (is_j) begin
          pc_wr = 1'b1;
          pcsrc = 2'b11;
        end else if (is_jr) begin
          pc_wr = 1'b1;
          pcsrc = 2'b01;
        end else if (is_jal) begin
          pc_wr  = 1'b1;
          pcsrc  = 2'b11;
          wr_reg = 1'b1;
        end
      end
      S_MEM: begin
        rd_mem = is_lw && !timeout;
        wr_mem = is_sw && !timeout;
        pc_wr  = is_sw && MemReady;
      end
      S_WB: begin
        wr_reg = 1'b1;
        pc_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by reset so an access aborts in the same cycle Rst rises.
  assign IrWrite = ir_wr  & ~Rst;
  assign PcWrite = pc_wr  & ~Rst;
  assign Rmem    = rd_mem & ~Rst;
  assign Wmem    = wr_mem & ~Rst;
  assign Wreg    = wr_reg & ~Rst;
  assign Pcsrc   = pcsrc;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wait_cnt <= (waiting && !MemReady) ? wait_cnt + 8'd1 : 8'd0;
      if (timeout) err_q <= 1'b1;
      if (pc_wr)   cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    Regrt   = 2'b00;
    Se      = 1'b0;
    Aluqb   = 1'b0;
    Aluc    = 2'b00;
    Reg2reg = 2'b00;
    if (is_addu) begin
      Aluqb   = 1'b1;
      Reg2reg = 2'b01;
    end else if (is_subu) begin
      Aluqb   = 1'b1;
      Aluc    = 2'b01;
      Reg2reg = 2'b01;
    end else if (is_ori || is_lui) begin
      Regrt   = 2'b01;
      Aluc    = 2'b10;
      Reg2reg = 2'b01;
    end else if (is_lw) begin
      Regrt = 2'b01;
      Se    = 1'b1;
    end else if (is_sw) begin
      Regrt   = 2'b01;
      Se      = 1'b1;
      Reg2reg = 2'b01;
    end else if (is_beq) begin
      Regrt   = 2'b01;
      Se      = 1'b1;
      Aluqb   = 1'b1;
      Aluc    = 2'b01;
      Reg2reg = 2'b01;
    end else if (is_jal) begin
      Regrt   = 2'b10;
      Aluqb   = 1'b1;
      Reg2reg = 2'b10;
    end
  end

  assign State      = state_q;
  assign Halted     = (state_q == S_HALT);
  assign Error      = err_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-cycle stimulus/expectation entries are queued per instruction and drained cycle by cycle.
module tb_multicycle_controller;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08, F_SYS = 6'h0c, F_ADDU = 6'h21, F_SUBU = 6'h23;
  localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WB = 3'd4, HA = 3'd5;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [5:0] Op = '0, Func = '0;
  logic       Z = 1'b0, MemReady = 1'b0;

  logic       IrWrite, PcWrite, Rmem, Wmem, Wreg, Se, Aluqb, Halted, Error;
  logic [1:0] Regrt, Aluc, Pcsrc, Reg2reg;
  logic [2:0] State;
  logic [3:0] InstrCount;

  logic       n_IrWrite, n_PcWrite, n_Rmem, n_Wmem, n_Wreg, n_Se, n_Aluqb, n_Halted, n_Error;
  logic [1:0] n_Regrt, n_Aluc, n_Pcsrc, n_Reg2reg;
  logic [2:0] n_State;
  logic [7:0] n_InstrCount;

  multicycle_controller #(.CNT_W(4), .HALT_ON_SYSCALL(1'b1), .WAIT_LIMIT(15)) dut (
    .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Z(Z), .MemReady(MemReady),
    .IrWrite(IrWrite), .PcWrite(PcWrite), .Rmem(Rmem), .Wmem(Wmem), .Wreg(Wreg),
    .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc), .Pcsrc(Pcsrc), .Reg2reg(Reg2reg),
    .State(State), .Halted(Halted), .Error(Error), .InstrCount(InstrCount)
  );

  multicycle_controller #(.CNT_W(8), .HALT_ON_SYSCALL(1'b0), .WAIT_LIMIT(1)) u_nosys (
    .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Z(Z), .MemReady(MemReady),
    .IrWrite(n_IrWrite), .PcWrite(n_PcWrite), .Rmem(n_Rmem), .Wmem(n_Wmem), .Wreg(n_Wreg),
    .Regrt(n_Regrt), .Se(n_Se), .Aluqb(n_Aluqb), .Aluc(n_Aluc), .Pcsrc(n_Pcsrc), .Reg2reg(n_Reg2reg),
    .State(n_State), .Halted(n_Halted), .Error(n_Error), .InstrCount(n_InstrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic       mr;
    logic       z;
    logic [2:0] st;
    logic [4:0] stb;   // {IrWrite, PcWrite, Rmem, Wmem, Wreg}
    logic [1:0] pcsrc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [5:0] func, input logic mr, input logic z,
                      input logic [2:0] st, input logic [4:0] stb, input logic [1:0] pcsrc);
    exp_t e;
    e.op = op; e.func = func; e.mr = mr; e.z = z; e.st = st; e.stb = stb; e.pcsrc = pcsrc;
    sb.push_back(e);
  endtask

  task automatic i_alu(input logic [5:0] op, input logic [5:0] func);
    push(op, func, 1'b1, 1'b0, FE, 5'b10100, 2'b00);
    push(op, func, 1'b1, 1'b0, DE, 5'b00000, 2'b00);
    push(op, func, 1'b1, 1'b0, EX, 5'b00000, 2'b00);
    push(op, func, 1'b1, 1'b0, WB, 5'b01001, 2'b00);
  endtask

  task automatic i_lw();
    push(OP_LW, 6'h00, 1'b1, 1'b0, FE, 5'b10100, 2'b00);
    push(OP_LW, 6'h00, 1'b1, 1'b0, DE, 5'b00000, 2'b00);
    push(OP_LW, 6'h00, 1'b1, 1'b0, EX, 5'b00000, 2'b00);
    push(OP_LW, 6'h00, 1'b1, 1'b0, ME, 5'b00100, 2'b00);
    push(OP_LW, 6'h00, 1'b1, 1'b0, WB, 5'b01001, 2'b00);
  endtask

  task automatic sw_head();
    push(OP_SW, 6'h00, 1'b1, 1'b0, FE, 5'b10100, 2'b00);
    push(OP_SW, 6'h00, 1'b1, 1'b0, DE, 5'b00000, 2'b00);
    push(OP_SW, 6'h00, 1'b1, 1'b0, EX, 5'b00000, 2'b00);
  endtask

  task automatic i_sw(input int nlow);
    sw_head();
    for (int k = 0; k < nlow; k++) push(OP_SW, 6'h00, 1'b0, 1'b0, ME, 5'b00010, 2'b00);
    push(OP_SW, 6'h00, 1'b1, 1'b0, ME, 5'b01010, 2'b00);
  endtask

  task automatic i_flow(input logic [5:0] op, input logic [5:0] func, input logic z,
                        input logic [4:0] stb, input logic [1:0] pcsrc);
    push(op, func, 1'b1, z, FE, 5'b10100, 2'b00);
    push(op, func, 1'b1, z, DE, 5'b00000, 2'b00);
    push(op, func, 1'b1, z, EX, stb, pcsrc);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Op = e.op; Func = e.func; MemReady = e.mr; Z = e.z;
      #1;
      check($sformatf("cyc%0d_state%0d", cyc, e.st),
            {22'd0, State, IrWrite, PcWrite, Rmem, Wmem, Wreg, Pcsrc},
            {22'd0, e.st, e.stb, e.pcsrc});
      cyc++;
      @(negedge Clk);
    end
  endtask

  task automatic sel_check(input string tag, input logic [5:0] op, input logic [5:0] func,
                           input logic [7:0] exp);
    Op = op; Func = func;
    #1;
    check({"sel_", tag}, {24'd0, Regrt, Se, Aluqb, Aluc, Reg2reg}, {24'd0, exp});
  endtask

  task automatic rst_pulse();
    #2 Rst = 1'b1;
    #1;
    check("rst_async_state_strobes", {State, IrWrite, PcWrite, Rmem, Wmem, Wreg}, 8'd0);
    check("rst_async_flags_count", {Halted, Error, InstrCount}, 6'd0);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    // Reset state, strobes masked while Rst is high
    @(negedge Clk);
    MemReady = 1'b1;
    #1;
    check("reset_state_strobes", {State, IrWrite, PcWrite, Rmem, Wmem, Wreg}, 8'd0);
    check("reset_flags_count", {Halted, Error, InstrCount}, 6'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // addu then lw with MemReady always high
    i_alu(OP_R, F_ADDU);
    i_lw();
    drain();
    check("count_addu_lw", InstrCount, 4'd2);

    // control flow and remaining ALU ops
    i_flow(OP_BEQ, 6'h00, 1'b1, 5'b01000, 2'b10);
    i_flow(OP_BEQ, 6'h00, 1'b0, 5'b01000, 2'b00);
    i_flow(OP_J,   6'h00, 1'b0, 5'b01000, 2'b11);
    i_flow(OP_R,   F_JR,  1'b0, 5'b01000, 2'b01);
    i_flow(OP_JAL, 6'h00, 1'b0, 5'b01001, 2'b11);
    i_alu(OP_R, F_SUBU);
    i_alu(OP_ORI, 6'h00);
    i_alu(OP_LUI, 6'h00);
    drain();
    check("count_flow", InstrCount, 4'd10);

    // sw stalled 3 cycles, then sw completing on the last permitted wait cycle
    i_sw(3);
    drain();
    check("count_sw3", InstrCount, 4'd11);
    check("error_sw3", Error, 1'b0);
    i_sw(14);
    drain();
    check("count_sw14", InstrCount, 4'd12);
    check("error_sw14", Error, 1'b0);

    // sw with MemReady low 15 cycles -> timeout, then HALT held
    sw_head();
    for (int k = 0; k < 14; k++) push(OP_SW, 6'h00, 1'b0, 1'b0, ME, 5'b00010, 2'b00);
    push(OP_SW, 6'h00, 1'b0, 1'b0, ME, 5'b00000, 2'b00);
    push(OP_SW, 6'h00, 1'b1, 1'b0, HA, 5'b00000, 2'b00);
    push(OP_R, F_ADDU, 1'b1, 1'b0, HA, 5'b00000, 2'b00);
    drain();
    check("timeout_halted_error", {Halted, Error}, 2'b11);
    check("timeout_count", InstrCount, 4'd12);

    // static selects
    sel_check("addu", OP_R, F_ADDU, 8'b00_0_1_00_01);
    sel_check("subu", OP_R, F_SUBU, 8'b00_0_1_01_01);
    sel_check("ori",  OP_ORI, 6'h00, 8'b01_0_0_10_01);
    sel_check("lui",  OP_LUI, 6'h00, 8'b01_0_0_10_01);
    sel_check("lw",   OP_LW,  6'h00, 8'b01_1_0_00_00);
    sel_check("sw",   OP_SW,  6'h00, 8'b01_1_0_00_01);
    sel_check("beq",  OP_BEQ, 6'h00, 8'b01_1_1_01_01);
    sel_check("jal",  OP_JAL, 6'h00, 8'b10_0_1_00_10);
    sel_check("j",    OP_J,   6'h00, 8'b00_0_0_00_00);
    sel_check("jr",   OP_R,   F_JR,  8'b00_0_0_00_00);
    sel_check("illegal", 6'h3f, 6'h00, 8'b00_0_0_00_00);
    @(negedge Clk);

    // asynchronous reset out of HALT with Error set
    rst_pulse();

    // syscall: main halts after DECODE; the no-halt variant retires it
    push(OP_R, F_SYS, 1'b1, 1'b0, FE, 5'b10100, 2'b00);
    push(OP_R, F_SYS, 1'b1, 1'b0, DE, 5'b00000, 2'b00);
    drain();
    MemReady = 1'b0;
    #1;
    check("syscall_halt", {State, Halted, Error}, {HA, 2'b10});
    check("syscall_count", InstrCount, 4'd0);
    check("nosys_fetch_count", {n_State, n_InstrCount}, {FE, 8'd1});
    check("nosys_timeout_no_rmem", n_Rmem, 1'b0);
    @(negedge Clk);
    #1;
    check("nosys_timeout_halt", {n_State, n_Halted, n_Error}, {HA, 2'b11});
    @(negedge Clk);
    rst_pulse();

    // 16 illegal instructions wrap the 4-bit counter
    for (int i = 0; i < 15; i++) begin
      push(6'h10 + 6'(i), 6'h00, 1'b1, 1'b0, FE, 5'b10100, 2'b00);
      push(6'h10 + 6'(i), 6'h00, 1'b1, 1'b0, DE, 5'b01000, 2'b00);
    end
    drain();
    check("count_15_illegal", InstrCount, 4'd15);
    push(OP_R, 6'h20, 1'b1, 1'b0, FE, 5'b10100, 2'b00);
    push(OP_R, 6'h20, 1'b1, 1'b0, DE, 5'b01000, 2'b00);
    drain();
    check("count_wrap", InstrCount, 4'd0);

    // reset asserted mid-MEM with Wmem high
    sw_head();
    drain();
    MemReady = 1'b0;
    #1;
    check("mem_wmem_high", {State, IrWrite, PcWrite, Rmem, Wmem, Wreg}, {ME, 5'b00010});
    #2 Rst = 1'b1;
    #1;
    check("mem_rst_wmem_drop", {State, IrWrite, PcWrite, Rmem, Wmem, Wreg}, 8'd0);
    @(negedge Clk);
    #1;
    check("mem_rst_held", {State, IrWrite, PcWrite, Rmem, Wmem, Wreg, InstrCount}, 12'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("first_fetch_after_rst", {State, IrWrite, PcWrite, Rmem, Wmem, Wreg}, {FE, 5'b00100});
    @(negedge Clk);
    #1;
    check("no_partial_retire", {State, InstrCount, Error}, {FE, 4'd0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
